// File: rtl/seq_fsm_param_pattern_mo_if.sv
// Bus bundle for the parametrised pattern detector: control/symbol in, state/flags/count out.
interface seq_fsm_param_pattern_mo_if #(
  parameter int W     = 2,
  parameter int SW    = 2,
  parameter int CNT_W = 4
);
  logic             en;
  logic             clr;
  logic [W-1:0]     in_;
  logic [SW-1:0]    state;
  logic [1:0]       out;
  logic [CNT_W-1:0] count;

  modport master (output en, clr, in_, input state, out, count);
  modport slave  (input en, clr, in_, output state, out, count);
endinterface

// File: rtl/seq_fsm_param_pattern_mo.sv
// Moore detector for a LEN-symbol pattern with KMP failure links and a saturating hit counter.
// The whole transition table is folded into a constant at elaboration; state = symbols matched.
module seq_fsm_param_pattern_mo #(
  parameter int               W       = 2,
  parameter int               LEN     = 3,
  parameter logic [LEN*W-1:0] PATTERN = 6'b100110,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 4,
  parameter int               SW      = $clog2(LEN + 1)
) (
  input logic                      clk,
  input logic                      reset,
  seq_fsm_param_pattern_mo_if.slave bus
);

  localparam int unsigned   NSYM    = 1 << W;
  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(LEN);

  typedef logic [(1 << (SW + W))-1:0][SW-1:0] tbl_t;

  function automatic logic [W-1:0] sym(input int unsigned i);
    return PATTERN[i*W +: W];
  endfunction

  // Symbol j of the string (sym[0..s-1], x).
  function automatic logic [W-1:0] seq_at(input int unsigned s, input logic [W-1:0] x,
                                          input int unsigned j);
    return (j < s) ? sym(j) : x;
  endfunction

  function automatic int unsigned next_of(input int unsigned s, input logic [W-1:0] x);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned k = 1; k <= s + 1; k++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < k; i++)
        if (seq_at(s, x, s + 1 - k + i) != sym(i)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic int unsigned border();
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned b = 1; b < LEN; b++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < b; i++)
        if (sym(i) != sym(LEN - b + i)) ok = 1'b0;
      if (ok) best = b;
    end
    return best;
  endfunction

  localparam int unsigned B = (OVERLAP != 0) ? border() : 0;

  // Row LEN already folds in the post-match fallback to B; rows above LEN
  // are unreachable encodings and stay 0 so a forced bad state recovers.
  function automatic tbl_t build_tbl();
    tbl_t        t;
    int unsigned src;
    t = '0;
    for (int unsigned s = 0; s <= LEN; s++) begin
      src = (s == LEN) ? B : s;
      for (int unsigned x = 0; x < NSYM; x++)
        t[s*NSYM + x] = SW'(next_of(src, W'(x)));
    end
    return t;
  endfunction

  localparam tbl_t TBL = build_tbl();

  logic [SW-1:0]    r_state;
  logic [CNT_W-1:0] r_count;
  logic [SW-1:0]    w_next;
  logic             w_match;
  logic             w_partial;

  always_comb begin
    w_next = TBL[{r_state, bus.in_}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      if (bus.en) r_state <= w_next;
      if (bus.clr)
        r_count <= '0;
      else if (bus.en && (w_next == S_MATCH) && (r_count != '1))
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_match   = (r_state == S_MATCH);
  assign w_partial = (r_state != S_IDLE) && (r_state < S_MATCH);

  assign bus.state = r_state;
  assign bus.out   = {w_partial, w_match};
  assign bus.count = r_count;

endmodule
